// File: rtl/fft_ctrl_pkg.sv
// Shared types and constants for the FFT job arbiter: FSM states, mode encoding,
// parameter defaults and a one-hot-to-index helper.
package fft_ctrl_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_WAIT = 2'd2,
        ST_DONE = 2'd3
    } fft_state_t;

    localparam logic MODE_FFT  = 1'b0;
    localparam logic MODE_IFFT = 1'b1;

    localparam int LATENCY_DEFAULT = 4;
    localparam int TAGW_DEFAULT    = 4;

    // A two-way one-hot grant maps to its index through the upper bit alone.
    function automatic logic onehot2_idx(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/fft_job_arbiter_if.sv
// Requester, engine-control and result handshake bundle of the FFT job arbiter.
interface fft_job_arbiter_if
    import fft_ctrl_pkg::*;
#(
    parameter int TAGW = TAGW_DEFAULT
);
    logic [1:0]        req_valid;
    logic [1:0]        req_mode;
    logic [2*TAGW-1:0] req_tag;
    logic [1:0]        req_ready;
    logic              in_sel;
    logic              eng_mode;
    logic              eng_start;
    logic              res_valid;
    logic              res_ready;
    logic              res_src;
    logic [TAGW-1:0]   res_tag;
    logic              busy;

    modport master (
        output req_valid, req_mode, req_tag, res_ready,
        input  req_ready, in_sel, eng_mode, eng_start, res_valid, res_src, res_tag, busy
    );

    modport slave (
        input  req_valid, req_mode, req_tag, res_ready,
        output req_ready, in_sel, eng_mode, eng_start, res_valid, res_src, res_tag, busy
    );
endinterface

// File: rtl/fft_job_arbiter_rr_arb2.sv
// Two-way round-robin grant: ptr breaks ties, a lone requester always wins.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       ptr,
    output logic [1:0] grant
);

    // One-hot grant from the request pair and the tie-break pointer.
    always_comb begin
        grant = 2'b00;
        case (req)
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            2'b11:   grant = ptr ? 2'b10 : 2'b01;
            default: grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/fft_job_arbiter.sv
// Shares one FFT/IFFT engine between two requesters, one job in flight at a time,
// and holds the result with its owner and tag until the consumer accepts it.
module fft_job_arbiter
    import fft_ctrl_pkg::*;
#(
    parameter int LATENCY = LATENCY_DEFAULT,
    parameter int TAGW    = TAGW_DEFAULT
) (
    input logic              clk,
    input logic              reset,
    fft_job_arbiter_if.slave bus
);

    localparam logic [3:0] CNT_LOAD = 4'(LATENCY - 1);

    fft_state_t state;
    logic       rr_ptr;
    logic [3:0] cnt;
    logic [1:0] grant;
    logic       win;

    rr_arb2 u_arb (
        .req   (bus.req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    assign win = onehot2_idx(grant);

    // Accept is combinational so the winner sees it in its own request cycle.
    always_comb begin
        if ((state == ST_IDLE) && !reset) begin
            bus.req_ready = grant;
        end else begin
            bus.req_ready = 2'b00;
        end
    end

    // Job sequencing FSM with all engine and result outputs registered.
    always_ff @(posedge clk) begin
        if (reset) begin
            state         <= ST_IDLE;
            rr_ptr        <= 1'b0;
            cnt           <= 4'd0;
            bus.eng_start <= 1'b0;
            bus.res_valid <= 1'b0;
            bus.busy      <= 1'b0;
            bus.in_sel    <= 1'b0;
            bus.eng_mode  <= MODE_FFT;
            bus.res_src   <= 1'b0;
            bus.res_tag   <= {TAGW{1'b0}};
        end else begin
            case (state)
                ST_IDLE: begin
                    if (grant != 2'b00) begin
                        state         <= ST_LOAD;
                        rr_ptr        <= ~win;
                        bus.in_sel    <= win;
                        bus.eng_mode  <= bus.req_mode[win];
                        bus.res_src   <= win;
                        bus.res_tag   <= win ? bus.req_tag[2*TAGW-1:TAGW] : bus.req_tag[TAGW-1:0];
                        bus.eng_start <= 1'b1;
                        bus.busy      <= 1'b1;
                    end else begin
                        state <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    bus.eng_start <= 1'b0;
                    if (LATENCY == 1) begin
                        cnt           <= 4'd0;
                        state         <= ST_DONE;
                        bus.res_valid <= 1'b1;
                    end else begin
                        cnt   <= CNT_LOAD;
                        state <= ST_WAIT;
                    end
                end
                // The count hits zero on the same edge that enters DONE.
                ST_WAIT: begin
                    if (cnt <= 4'd1) begin
                        cnt           <= 4'd0;
                        state         <= ST_DONE;
                        bus.res_valid <= 1'b1;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                ST_DONE: begin
                    if (bus.res_ready) begin
                        state         <= ST_IDLE;
                        bus.res_valid <= 1'b0;
                        bus.busy      <= 1'b0;
                    end else begin
                        state <= ST_DONE;
                    end
                end
                default: begin
                    state         <= ST_IDLE;
                    bus.eng_start <= 1'b0;
                    bus.res_valid <= 1'b0;
                    bus.busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fft_job_arbiter.sv
// Drives two arbiter builds (LATENCY 4 and 1) from one random stimulus stream and
// checks each against a cycle-level job model through per-build event queues.
module tb_fft_job_arbiter;

    localparam int TW = 4;

    typedef struct {
        int         cyc;
        logic [1:0] grant;
        logic       src;
        logic       mode;
        logic [3:0] tag;
    } ev_t;

    logic       clk;
    logic       reset;
    logic [1:0] req_valid;
    logic [1:0] req_mode;
    logic [7:0] req_tag;
    logic       res_ready;
    int         cyc;
    int         total;
    int         bad;

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        cyc = 0;
        forever begin
            @(posedge clk);
            cyc = cyc + 1;
        end
    end

    for (genvar g = 0; g < 2; g++) begin : lane
        localparam int LAT = (g == 0) ? 4 : 1;

        fft_job_arbiter_if #(.TAGW(TW)) ifc ();

        assign ifc.req_valid = req_valid;
        assign ifc.req_mode  = req_mode;
        assign ifc.req_tag   = req_tag;
        assign ifc.res_ready = res_ready;

        fft_job_arbiter #(.LATENCY(LAT), .TAGW(TW)) dut (
            .clk   (clk),
            .reset (reset),
            .bus   (ifc)
        );

        ev_t  gq[$];
        ev_t  sq[$];
        ev_t  rq[$];
        ev_t  e;
        ev_t  f;
        logic m_busy = 1'b0;
        logic m_ptr  = 1'b0;
        logic m_sel  = 1'b0;
        logic m_mode = 1'b0;
        int   m_res_at = 0;
        logic busy_now = 1'b0;
        logic sel_now  = 1'b0;
        logic mode_now = 1'b0;
        logic rv_now   = 1'b0;
        logic w;

        // Job-level model: one job at a time, result LAT cycles after the start strobe.
        initial forever begin
            @(posedge clk);
            #2;
            busy_now = m_busy;
            sel_now  = m_sel;
            mode_now = m_mode;
            rv_now   = m_busy && (cyc >= m_res_at);
            if (reset) begin
                for (int i = gq.size() - 1; i >= 0; i--) if (gq[i].cyc > cyc) gq.delete(i);
                for (int i = sq.size() - 1; i >= 0; i--) if (sq[i].cyc > cyc) sq.delete(i);
                for (int i = rq.size() - 1; i >= 0; i--) if (rq[i].cyc > cyc) rq.delete(i);
                m_busy = 1'b0;
                m_ptr  = 1'b0;
            end else if (!m_busy) begin
                if (req_valid != 2'b00) begin
                    w       = (req_valid == 2'b11) ? m_ptr : req_valid[1];
                    e.grant = w ? 2'b10 : 2'b01;
                    e.src   = w;
                    e.mode  = req_mode[w];
                    e.tag   = w ? req_tag[7:4] : req_tag[3:0];
                    e.cyc   = cyc;
                    gq.push_back(e);
                    e.cyc   = cyc + 1;
                    sq.push_back(e);
                    e.cyc   = cyc + 1 + LAT;
                    rq.push_back(e);
                    m_res_at = cyc + 1 + LAT;
                    m_busy   = 1'b1;
                    m_ptr    = ~w;
                    m_sel    = w;
                    m_mode   = e.mode;
                end
            end else if ((cyc >= m_res_at) && res_ready) begin
                m_busy = 1'b0;
            end
        end

        logic       rst_prev = 1'b0;
        logic       rv_prev  = 1'b0;
        logic       held_src = 1'b0;
        logic [3:0] held_tag = 4'd0;

        // Monitor: compare DUT outputs against queued events mid-cycle.
        initial forever begin
            @(negedge clk);
            if (cyc >= 1) begin
                if (rst_prev) begin
                    total++;
                    if ({ifc.eng_start, ifc.res_valid, ifc.busy, ifc.in_sel, ifc.eng_mode,
                         ifc.res_src, ifc.res_tag} != 10'd0) begin
                        bad++;
                        $display("FAIL reset_state lane%0d cyc=%0d got es=%b rv=%b busy=%b sel=%b mode=%b src=%b tag=%h want all zero",
                                 g, cyc, ifc.eng_start, ifc.res_valid, ifc.busy, ifc.in_sel,
                                 ifc.eng_mode, ifc.res_src, ifc.res_tag);
                    end
                end
                if ((ifc.req_ready != 2'b00) || ((gq.size() > 0) && (gq[0].cyc <= cyc))) begin
                    total++;
                    if (gq.size() == 0) begin
                        bad++;
                        $display("FAIL grant lane%0d cyc=%0d got req_ready=%b want 00", g, cyc, ifc.req_ready);
                    end else begin
                        f = gq.pop_front();
                        if ((f.cyc != cyc) || (f.grant != ifc.req_ready)) begin
                            bad++;
                            $display("FAIL grant lane%0d cyc=%0d got req_ready=%b want %b at cyc %0d",
                                     g, cyc, ifc.req_ready, f.grant, f.cyc);
                        end
                    end
                end
                if (ifc.eng_start || ((sq.size() > 0) && (sq[0].cyc <= cyc))) begin
                    total++;
                    if (sq.size() == 0) begin
                        bad++;
                        $display("FAIL eng_start lane%0d cyc=%0d got unexpected strobe", g, cyc);
                    end else begin
                        f = sq.pop_front();
                        if ((f.cyc != cyc) || !ifc.eng_start || (ifc.in_sel != f.src) || (ifc.eng_mode != f.mode)) begin
                            bad++;
                            $display("FAIL eng_start lane%0d cyc=%0d got es=%b sel=%b mode=%b want es=1 sel=%b mode=%b at cyc %0d",
                                     g, cyc, ifc.eng_start, ifc.in_sel, ifc.eng_mode, f.src, f.mode, f.cyc);
                        end
                    end
                end
                if ((ifc.res_valid && !rv_prev) || ((rq.size() > 0) && (rq[0].cyc <= cyc))) begin
                    total++;
                    if (rq.size() == 0) begin
                        bad++;
                        $display("FAIL result lane%0d cyc=%0d got unexpected res_valid", g, cyc);
                    end else begin
                        f = rq.pop_front();
                        if ((f.cyc != cyc) || !ifc.res_valid || rv_prev || (ifc.res_src != f.src) || (ifc.res_tag != f.tag)) begin
                            bad++;
                            $display("FAIL result lane%0d cyc=%0d got rv=%b src=%b tag=%h want rising rv src=%b tag=%h at cyc %0d",
                                     g, cyc, ifc.res_valid, ifc.res_src, ifc.res_tag, f.src, f.tag, f.cyc);
                        end
                    end
                    held_src = ifc.res_src;
                    held_tag = ifc.res_tag;
                end else if (ifc.res_valid && rv_prev) begin
                    total++;
                    if ((ifc.res_src != held_src) || (ifc.res_tag != held_tag)) begin
                        bad++;
                        $display("FAIL result_hold lane%0d cyc=%0d got src=%b tag=%h want src=%b tag=%h",
                                 g, cyc, ifc.res_src, ifc.res_tag, held_src, held_tag);
                    end
                end
                total++;
                if ((ifc.busy != busy_now) || (ifc.res_valid != rv_now)) begin
                    bad++;
                    $display("FAIL busy_valid lane%0d cyc=%0d got busy=%b rv=%b want busy=%b rv=%b",
                             g, cyc, ifc.busy, ifc.res_valid, busy_now, rv_now);
                end
                if (busy_now) begin
                    total++;
                    if ((ifc.in_sel != sel_now) || (ifc.eng_mode != mode_now)) begin
                        bad++;
                        $display("FAIL hold_sel lane%0d cyc=%0d got sel=%b mode=%b want sel=%b mode=%b",
                                 g, cyc, ifc.in_sel, ifc.eng_mode, sel_now, mode_now);
                    end
                end
            end
            rst_prev = reset;
            rv_prev  = ifc.res_valid;
        end
    end

    task automatic step(input logic [1:0] v, input logic [1:0] m, input logic [7:0] t,
                        input logic rr, input logic rs);
        @(posedge clk);
        #1;
        req_valid = v;
        req_mode  = m;
        req_tag   = t;
        res_ready = rr;
        reset     = rs;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(2'b00, 2'b00, 8'h00, 1'b1, 1'b0);
    endtask

    initial begin
        total     = 0;
        bad       = 0;
        reset     = 1'b1;
        req_valid = 2'b00;
        req_mode  = 2'b00;
        req_tag   = 8'h00;
        res_ready = 1'b0;
        for (int i = 0; i < 3; i++) step(2'b00, 2'b00, 8'h00, 1'b0, 1'b1);
        idle(1);

        // Single IFFT job from requester 0 with tag 5.
        step(2'b01, 2'b01, 8'h05, 1'b1, 1'b0);
        idle(8);

        // Both requesters continuously valid, consumer always ready.
        for (int i = 0; i < 30; i++) step(2'b11, 2'b10, 8'h9A, 1'b1, 1'b0);
        idle(8);

        // Result stalled by the consumer while both requesters keep asking.
        step(2'b01, 2'b00, 8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 16; i++) step(2'b11, 2'b11, 8'h77, 1'b0, 1'b0);
        idle(8);

        // Reset in mid-job after requester 0 won, then a contended request.
        step(2'b01, 2'b00, 8'h01, 1'b1, 1'b0);
        step(2'b00, 2'b00, 8'h00, 1'b1, 1'b0);
        step(2'b00, 2'b00, 8'h00, 1'b1, 1'b1);
        step(2'b11, 2'b00, 8'h21, 1'b1, 1'b0);
        idle(8);

        // Lone requester 1 with pointer at 0, then contention goes back to 0.
        step(2'b00, 2'b00, 8'h00, 1'b1, 1'b1);
        step(2'b10, 2'b10, 8'hB0, 1'b1, 1'b0);
        idle(8);
        step(2'b11, 2'b01, 8'hC4, 1'b1, 1'b0);
        idle(8);

        for (int i = 0; i < 800; i++) begin
            step(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 99) == 0));
        end
        idle(12);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/fft_job_arbiter.md
FFT_JOB_ARBITER -- requirements
Module: fft_job_arbiter

Interface
REQ-001 SHALL have parameter LATENCY, default 4: cycles from eng_start to engine output valid; legal range 1..15.
REQ-002 SHALL have parameter TAGW, default 4: width of the job tag.
REQ-003 SHALL have port clk, input, 1 bit: clock; all state updates on rising edge.
REQ-004 SHALL have port reset, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 2 bits: per-requester job request, index 0 and 1.
REQ-006 SHALL have port req_mode, input, 2 bits: per-requester mode; 0 = FFT, 1 = IFFT.
REQ-007 SHALL have port req_tag, input, 2xTAGW bits: per-requester job tag.
REQ-008 SHALL have port req_ready, output, 2 bits: grant/accept, one-hot or zero.
REQ-009 SHALL have port in_sel, output, 1 bit: engine input mux select (requester index of the current job).
REQ-010 SHALL have port eng_mode, output, 1 bit: mode driven to the shared FFT/IFFT engine.
REQ-011 SHALL have port eng_start, output, 1 bit: single-cycle engine load strobe.
REQ-012 SHALL have port res_valid, output, 1 bit: engine result available.
REQ-013 SHALL have port res_ready, input, 1 bit: result consumer accept.
REQ-014 SHALL have port res_src, output, 1 bit: requester index owning the result.
REQ-015 SHALL have port res_tag, output, TAGW bits: tag of the job owning the result.
REQ-016 SHALL have port busy, output, 1 bit: high in every state except IDLE.

Function
REQ-017 SHALL implement the states IDLE, LOAD, WAIT and DONE, with at most one job outstanding.
REQ-018 In IDLE with any req_valid bit set, SHALL assert req_ready for exactly one requester in the same cycle, combinationally from state and req_valid.
REQ-019 Arbitration SHALL be round-robin: when both requesters are valid, the requester named by pointer rr_ptr wins; when only one is valid, that requester wins regardless of rr_ptr.
REQ-020 On grant, SHALL capture the winner's mode, tag and index, then move to LOAD; rr_ptr SHALL become the non-winner index.
REQ-021 In LOAD, SHALL assert eng_start for exactly one cycle, load the counter with LATENCY-1 (LATENCY=1 goes directly to DONE), then move to WAIT.
REQ-022 In WAIT, SHALL decrement the counter each cycle and move to DONE when it reaches 0.
REQ-023 res_valid SHALL first be high exactly LATENCY cycles after the eng_start cycle.
REQ-024 In DONE, SHALL hold res_valid, res_src and res_tag stable until res_ready is high, then return to IDLE on the next edge.
REQ-025 req_ready SHALL be 0 in LOAD, WAIT and DONE, regardless of req_valid.
REQ-026 res_ready SHALL be ignored outside DONE.
REQ-027 in_sel and eng_mode SHALL hold the captured values from grant until the return to IDLE.
REQ-028 A requester that drops req_valid before grant SHALL lose its turn without any change to rr_ptr.
REQ-029 Minimum job period SHALL be LATENCY+2 cycles when res_ready is tied high; a new grant is issued in the IDLE cycle following DONE.

Reset
REQ-030 reset SHALL force: state to IDLE, rr_ptr to 0, counter to 0, and req_ready, eng_start, res_valid, busy, in_sel, eng_mode, res_src and res_tag to 0.
REQ-031 Reset asserted mid-job (LOAD, WAIT or DONE) SHALL abandon the job, with no res_valid issued for it.
REQ-032 reset SHALL take priority over all other inputs.

Structure
REQ-033 Package fft_ctrl_pkg SHALL hold: the state enum, the FFT/IFFT mode encoding constants, and the defaults for LATENCY and TAGW.
REQ-034 A sub-module rr_arb2 SHALL implement the 2-way round-robin grant (inputs req and ptr; output one-hot grant); everything else SHALL be inlined.

Verification
REQ-035 Bench SHALL cover: reset, then req_valid=01, mode=1, tag=5 -> req_ready=01 same cycle; eng_start one cycle later with eng_mode=1, in_sel=0; res_valid 4 cycles after eng_start with res_src=0, res_tag=5.
REQ-036 Bench SHALL cover: both requesters valid continuously, res_ready=1 -> grants alternate 0,1,0,1 with period 6 cycles at LATENCY=4.
REQ-037 Bench SHALL cover: res_ready held 0 for 10 cycles in DONE -> res_valid and res_tag stable, req_ready=00 throughout; completes on the first res_ready=1.
REQ-038 Bench SHALL cover: reset pulsed in WAIT -> no res_valid; next job grants requester 0 when both are valid.
REQ-039 Bench SHALL cover: LATENCY=1 build -> res_valid in the cycle after eng_start.
REQ-040 Bench SHALL cover: req_valid=10 only with rr_ptr=0 -> requester 1 granted, rr_ptr becomes 0.
